// File: rtl/cmd_arb_pkg.sv
// Shared definitions for the command arbiter: FSM state codes, opcode values
// and a STOP-detect helper that the command controller also uses.
package cmd_arb_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PRESENT = 2'd1;
   localparam logic [1:0] ST_ACK     = 2'd2;

   localparam logic [1:0] STOP_OP = 2'b00;
   localparam logic [1:0] GO_OP   = 2'b01;

   function automatic logic is_stop(input logic [7:0] c);
      return c[7:6] == STOP_OP;
   endfunction

endpackage

// File: rtl/cmd_to_timer.sv
// Timeout counter for a presented command: loadable, clearable, and flags
// its terminal count at TO_CYCLES-1.
module cmd_to_timer #(
   parameter int TO_CYCLES = 1024,
   parameter int CNT_W     = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             tc
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en)
         count <= count + CNT_W'(1);
   end

   assign tc = (count == CNT_W'(TO_CYCLES - 1));

endmodule

// File: rtl/cmd_arb.sv
// Two-source command arbiter: STOP first, round-robin otherwise, one command
// in flight, and a timeout that drops commands the consumer never clears.
module cmd_arb
   import cmd_arb_pkg::*;
#(
   parameter int TO_CYCLES = 1024,
   parameter int CNT_W     = 11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] cmd_a,
   input  logic       cmd_rdy_a,
   output logic       clr_cmd_rdy_a,
   input  logic [7:0] cmd_b,
   input  logic       cmd_rdy_b,
   output logic       clr_cmd_rdy_b,
   output logic [7:0] cmd,
   output logic       cmd_rdy,
   input  logic       clr_cmd_rdy,
   output logic       grant_b,
   output logic       timeout,
   output logic [7:0] drop_cnt
);

   logic [1:0] state;
   logic       last_grant_b;
   logic       win_valid;
   logic       win_b;
   logic       to_tc;

   cmd_to_timer #(
      .TO_CYCLES(TO_CYCLES),
      .CNT_W    (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (state != ST_PRESENT),
      .en      (state == ST_PRESENT),
      .load    (1'b0),
      .load_val({CNT_W{1'b0}}),
      .tc      (to_tc)
   );

   // A lone STOP beats round-robin; otherwise the source not served last wins.
   always_comb begin
      win_valid = cmd_rdy_a | cmd_rdy_b;
      win_b     = 1'b0;
      if (cmd_rdy_a && cmd_rdy_b) begin
         if (is_stop(cmd_a) != is_stop(cmd_b))
            win_b = is_stop(cmd_b);
         else
            win_b = ~last_grant_b;
      end else begin
         win_b = cmd_rdy_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         cmd           <= 8'h00;
         cmd_rdy       <= 1'b0;
         clr_cmd_rdy_a <= 1'b0;
         clr_cmd_rdy_b <= 1'b0;
         timeout       <= 1'b0;
         drop_cnt      <= 8'h00;
         last_grant_b  <= 1'b1;
         grant_b       <= 1'b0;
      end else begin
         clr_cmd_rdy_a <= 1'b0;
         clr_cmd_rdy_b <= 1'b0;
         timeout       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (win_valid) begin
                  cmd     <= win_b ? cmd_b : cmd_a;
                  grant_b <= win_b;
                  cmd_rdy <= 1'b1;
                  state   <= ST_PRESENT;
               end
            end
            // A consumer clear in the terminal-count cycle is a normal consume.
            ST_PRESENT: begin
               if (clr_cmd_rdy || to_tc) begin
                  cmd_rdy       <= 1'b0;
                  clr_cmd_rdy_a <= ~grant_b;
                  clr_cmd_rdy_b <= grant_b;
                  last_grant_b  <= grant_b;
                  state         <= ST_ACK;
                  if (!clr_cmd_rdy) begin
                     timeout <= 1'b1;
                     if (drop_cnt != 8'hFF)
                        drop_cnt <= drop_cnt + 8'd1;
                  end
               end
            end
            ST_ACK:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_arb.sv
// Self-checking bench for cmd_arb: directed timing sequences, a vector table
// for arbitration decisions, and randomized traffic against a transaction model.
module tb_cmd_arb;

   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] cmd_a, cmd_b, cmd, drop_cnt;
   logic       cmd_rdy_a, cmd_rdy_b, clr_cmd_rdy_a, clr_cmd_rdy_b;
   logic       cmd_rdy, clr_cmd_rdy, grant_b, timeout;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       ra;
      logic       rb;
      logic [7:0] ba;
      logic [7:0] bb;
      logic       exp_b;
      logic [7:0] exp_cmd;
   } vec_t;

   vec_t vecs[10];

   cmd_arb #(.TO_CYCLES(TO), .CNT_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_a        (cmd_a),
      .cmd_rdy_a    (cmd_rdy_a),
      .clr_cmd_rdy_a(clr_cmd_rdy_a),
      .cmd_b        (cmd_b),
      .cmd_rdy_b    (cmd_rdy_b),
      .clr_cmd_rdy_b(clr_cmd_rdy_b),
      .cmd          (cmd),
      .cmd_rdy      (cmd_rdy),
      .clr_cmd_rdy  (clr_cmd_rdy),
      .grant_b      (grant_b),
      .timeout      (timeout),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input logic ra, input logic rb, input logic [7:0] ba,
                                 input logic [7:0] bb, input logic clr);
      cmd_rdy_a   = ra;
      cmd_rdy_b   = rb;
      cmd_a       = ba;
      cmd_b       = bb;
      clr_cmd_rdy = clr;
   endtask

   // Spec-level arbitration rule: lone requester, then lone STOP, then round-robin.
   function automatic logic pick_b(input logic ra, input logic rb, input logic [7:0] ba,
                                   input logic [7:0] bb, input logic last_b);
      logic sa, sb;
      sa = (ba[7:6] == 2'b00);
      sb = (bb[7:6] == 2'b00);
      if (ra && !rb) return 1'b0;
      if (!ra && rb) return 1'b1;
      if (sa && !sb) return 1'b0;
      if (sb && !sa) return 1'b1;
      return ~last_b;
   endfunction

   // One full transaction starting at an IDLE negedge; consumer clears after
   // 'delay' cycles of cmd_rdy, or the command is dropped if delay >= TO.
   task automatic run_txn(input logic ra, input logic rb, input logic [7:0] ba, input logic [7:0] bb,
                          input int delay, input logic exp_b, input logic [7:0] exp_cmd,
                          input logic exp_drop, input logic [7:0] exp_cnt, input string tag);
      int         last_i;
      logic [7:0] garb;
      apply_stimulus(ra, rb, ba, bb, 1'b0);
      @(negedge clk);
      check_output({tag, " cmd_rdy rise"}, {7'd0, cmd_rdy}, 8'd1);
      check_output({tag, " cmd"}, cmd, exp_cmd);
      check_output({tag, " grant_b"}, {7'd0, grant_b}, {7'd0, exp_b});
      last_i = (delay < TO) ? delay : TO - 1;
      for (int i = 0; i <= last_i; i++) begin
         garb = 8'($urandom);
         apply_stimulus(ra, rb, exp_b ? ba : garb, exp_b ? garb : bb, i == delay);
         @(negedge clk);
         if (i < last_i) begin
            check_output({tag, " cmd_rdy held"}, {7'd0, cmd_rdy}, 8'd1);
            check_output({tag, " cmd stable"}, cmd, exp_cmd);
            check_output({tag, " early timeout"}, {7'd0, timeout}, 8'd0);
         end
      end
      check_output({tag, " cmd_rdy fall"}, {7'd0, cmd_rdy}, 8'd0);
      check_output({tag, " clr_a"}, {7'd0, clr_cmd_rdy_a}, {7'd0, ~exp_b});
      check_output({tag, " clr_b"}, {7'd0, clr_cmd_rdy_b}, {7'd0, exp_b});
      check_output({tag, " timeout"}, {7'd0, timeout}, {7'd0, exp_drop});
      check_output({tag, " drop_cnt"}, drop_cnt, exp_cnt);
      apply_stimulus(exp_b ? ra : 1'b0, exp_b ? 1'b0 : rb, ba, bb, 1'b0);
      @(negedge clk);
      check_output({tag, " idle clr_a"}, {7'd0, clr_cmd_rdy_a}, 8'd0);
      check_output({tag, " idle clr_b"}, {7'd0, clr_cmd_rdy_b}, 8'd0);
      check_output({tag, " idle cmd_rdy"}, {7'd0, cmd_rdy}, 8'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic       pa, pb, wb, last_b, drop;
      logic [7:0] ba, bb;
      int         drops, d;

      vecs[0] = '{1'b1, 1'b0, 8'h45, 8'h00, 1'b0, 8'h45};
      vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h80, 1'b1, 8'h80};
      vecs[2] = '{1'b1, 1'b1, 8'h41, 8'h42, 1'b0, 8'h41};
      vecs[3] = '{1'b1, 1'b1, 8'h41, 8'h42, 1'b1, 8'h42};
      vecs[4] = '{1'b1, 1'b1, 8'h41, 8'h00, 1'b1, 8'h00};
      vecs[5] = '{1'b1, 1'b1, 8'h3F, 8'hC5, 1'b0, 8'h3F};
      vecs[6] = '{1'b1, 1'b1, 8'h00, 8'h01, 1'b1, 8'h01};
      vecs[7] = '{1'b1, 1'b1, 8'hC0, 8'h81, 1'b0, 8'hC0};
      vecs[8] = '{1'b1, 1'b0, 8'hC0, 8'h00, 1'b0, 8'hC0};
      vecs[9] = '{1'b1, 1'b1, 8'h80, 8'hFF, 1'b1, 8'hFF};

      // Single source with exact cycle timing
      do_reset();
      @(negedge clk);
      check_output("reset cmd", cmd, 8'h00);
      check_output("reset cmd_rdy", {7'd0, cmd_rdy}, 8'd0);
      check_output("reset grant_b", {7'd0, grant_b}, 8'd0);
      check_output("reset drop_cnt", drop_cnt, 8'h00);
      check_output("reset timeout", {7'd0, timeout}, 8'd0);
      apply_stimulus(1'b1, 1'b0, 8'h45, 8'h00, 1'b0);
      @(negedge clk);
      check_output("t1 cmd", cmd, 8'h45);
      check_output("t1 cmd_rdy", {7'd0, cmd_rdy}, 8'd1);
      check_output("t1 grant_b", {7'd0, grant_b}, 8'd0);
      @(negedge clk);
      check_output("t1 hold", {7'd0, cmd_rdy}, 8'd1);
      @(negedge clk);
      check_output("t1 no early clr", {7'd0, clr_cmd_rdy_a}, 8'd0);
      apply_stimulus(1'b1, 1'b0, 8'h45, 8'h00, 1'b1);
      @(negedge clk);
      check_output("t1 clr_a pulse", {7'd0, clr_cmd_rdy_a}, 8'd1);
      check_output("t1 cmd_rdy low", {7'd0, cmd_rdy}, 8'd0);
      apply_stimulus(1'b0, 1'b0, 8'h45, 8'h00, 1'b0);
      @(negedge clk);
      check_output("t1 clr_a end", {7'd0, clr_cmd_rdy_a}, 8'd0);
      @(negedge clk);
      check_output("t1 no regrant", {7'd0, cmd_rdy}, 8'd0);

      // Arbitration table from a fresh reset (last grant = B)
      do_reset();
      for (int i = 0; i < 10; i++)
         run_txn(vecs[i].ra, vecs[i].rb, vecs[i].ba, vecs[i].bb, 0,
                 vecs[i].exp_b, vecs[i].exp_cmd, 1'b0, 8'h00, $sformatf("vec%0d", i));

      // Consumer clear in the terminal-count cycle; then a clear at the last legal cycle
      run_txn(1'b1, 1'b0, 8'h55, 8'h00, TO - 1, 1'b0, 8'h55, 1'b0, 8'h00, "race");
      run_txn(1'b0, 1'b1, 8'h00, 8'h66, TO - 2, 1'b1, 8'h66, 1'b0, 8'h00, "late clr");

      // Repeated timeouts: drop_cnt saturates at 255
      for (int r = 0; r < 300; r++)
         run_txn(1'b0, 1'b1, 8'h00, 8'h7F, 100, 1'b1, 8'h7F, 1'b1,
                 (r + 1 > 255) ? 8'hFF : 8'(r + 1), $sformatf("drop%0d", r));

      // Reset while presenting, with A still waiting
      apply_stimulus(1'b1, 1'b0, 8'h99, 8'h00, 1'b0);
      @(negedge clk);
      check_output("t6 presenting", {7'd0, cmd_rdy}, 8'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_output("t6 cmd_rdy", {7'd0, cmd_rdy}, 8'd0);
      check_output("t6 cmd", cmd, 8'h00);
      check_output("t6 drop_cnt", drop_cnt, 8'h00);
      check_output("t6 clr pulses", {6'd0, clr_cmd_rdy_a, clr_cmd_rdy_b}, 8'd0);
      check_output("t6 timeout", {7'd0, timeout}, 8'd0);
      @(negedge clk);
      check_output("t6 regrant", {7'd0, cmd_rdy}, 8'd1);
      check_output("t6 regrant cmd", cmd, 8'h99);
      apply_stimulus(1'b1, 1'b0, 8'h99, 8'h00, 1'b1);
      @(negedge clk);
      check_output("t6 clr_a", {7'd0, clr_cmd_rdy_a}, 8'd1);
      apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);

      // Randomized traffic against the transaction-level model
      last_b = 1'b0;
      drops  = 0;
      pa = 1'b0; pb = 1'b0; ba = 8'h00; bb = 8'h00;
      for (int n = 0; n < 200; n++) begin
         if (!pa && ($urandom_range(1, 0) == 1)) begin pa = 1'b1; ba = 8'($urandom); end
         if (!pb && ($urandom_range(1, 0) == 1)) begin pb = 1'b1; bb = 8'($urandom); end
         if (!pa && !pb) begin pa = 1'b1; ba = 8'($urandom); end
         wb   = pick_b(pa, pb, ba, bb, last_b);
         d    = $urandom_range(TO + 3, 0);
         drop = (d >= TO);
         if (drop) drops++;
         run_txn(pa, pb, ba, bb, d, wb, wb ? bb : ba, drop,
                 (drops > 255) ? 8'hFF : 8'(drops), $sformatf("rnd%0d", n));
         last_b = wb;
         if (wb) pb = 1'b0; else pa = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
